pix_pack_240: RTL and testbench
===============================

# pix_pack_240

Write-side pixel packer feeding the 240-bit, 32-deep pixel buffer FIFO. Accepts one 24-bit pixel per cycle over a valid/ready handshake and packs ten consecutive pixels into one 240-bit word, first pixel in the least significant slot. Issues a single-cycle FIFO write per completed word. Flushes a zero-padded partial word at end of line. Applies backpressure from the FIFO almost-full flag.

## Interface
Parameters:
- PIX_W, 24, pixel width in bits
- PIX_PER_WORD, 10, pixels per FIFO word; PIX_W*PIX_PER_WORD must equal 240
- CNT_W, 16, width of the word counter

Ports:
- wr_clk  in  1  write-domain clock; the only clock in the block
- wr_rst  in  1  synchronous, active-high reset
- pix_valid  in  1  pixel present on pix_data
- pix_ready  out  1  block can accept a pixel this cycle
- pix_data  in  PIX_W  pixel value
- pix_eol  in  1  last pixel of the line; qualified by the accept condition
- fifo_wr_en  out  1  FIFO write strobe, one cycle per word
- fifo_wr_data  out  240  packed word; valid when fifo_wr_en=1
- fifo_almost_full  in  1  FIFO almost-full flag (threshold 25 words)
- fifo_full  in  1  FIFO full flag
- word_cnt  out  CNT_W  total words written since reset; wraps modulo 2^CNT_W
- ovf_err  out  1  sticky: a write was issued while fifo_full=1

## Operation
- Accept: acc = pix_valid & pix_ready. pix_ready = ~fifo_almost_full & ~fifo_full & ~wr_rst (combinational). Backpressure only; 7 words of FIFO headroom above threshold.
- Accumulator: 240-bit register plus slot index k (0..PIX_PER_WORD-1). On acc, pix_data is written to bits [PIX_W*k+PIX_W-1 : PIX_W*k].
- States:
  - EMPTY (k=0, accumulator all zero)
  - FILL (0<k≤9)
- Transitions:
  - On acc with k<9 and pix_eol=0: k increments; EMPTY moves to FILL.
  - On acc with k=9, or on acc with pix_eol=1 at any k: the word, including this pixel, is copied to the output register. Accumulator clears to zero, k goes to 0, state goes to EMPTY.
- EOL flush: any slots not yet filled are zero. EOL with k=0 produces a word holding only slot 0.
- Output register: fifo_wr_en=1 for exactly the cycle after the completing accept; otherwise 0. fifo_wr_data holds the last completed word and is not cleared between writes.
- Counters:
  - word_cnt increments by 1 on every fifo_wr_en cycle.
  - ovf_err is set when fifo_wr_en=1 and fifo_full=1 in the same cycle. The write is still issued, and the FIFO drops it.
  - ovf_err clears only on wr_rst.
- pix_data and pix_eol are ignored when acc=0.

## Timing
- Reset values:
  - pix_ready=0 while wr_rst=1
  - fifo_wr_en=0, fifo_wr_data=0, word_cnt=0, ovf_err=0, k=0, accumulator=0
- Latency: the completing accept at cycle n gives fifo_wr_en=1 at cycle n+1.
- Throughput: one pixel per cycle sustained, with no bubble at word boundaries. A pixel accepted at cycle n+1 lands in slot 0 of the next word while the previous word is being written.
- Back-to-back EOLs: two consecutive accepts with pix_eol=1 give fifo_wr_en=1 on two consecutive cycles.
- almost_full rising at cycle m: pix_ready=0 in cycle m; no accept in cycle m. A word completed at m-1 is still written at m.
- Reset mid-word: the partial accumulator is discarded and no write is issued. A word already in the output register at the reset cycle is not written; fifo_wr_en=0 from the reset cycle onward.
- Wrap-around: word_cnt goes from 2^CNT_W-1 to 0 on the next write; ovf_err is unaffected.

## Test plan
- Reset, then 10 accepts of pix_data=1..10 on consecutive cycles, pix_eol=0 → one fifo_wr_en pulse at cycle 11. Slot k holds k+1 (bits[23:0]=1, bits[239:216]=10). word_cnt=1.
- 100 consecutive pixels 0..99 → 10 pulses on cycles 11,21,…,101. Word 5 slot 0 = 50. No missed pixels.
- 13 pixels with pix_eol on the 13th → word 1 full. Word 2 has slots 0..2 = pixels 10..12 and bits[239:72]=0. Next pixel starts at slot 0.
- Assert fifo_almost_full for 5 cycles mid-word with pix_valid held high → pix_ready=0 for those 5 cycles and accepts pause. Resulting word is identical to the unstalled case.
- 4 pixels, then wr_rst for 1 cycle, then 10 pixels 0xA..0x13 → no write for the first 4 pixels. One write with slot 0 = 0xA. word_cnt=1.
- Force fifo_full=1 during a write cycle → ovf_err=1 and stays 1 after fifo_full drops. word_cnt still increments. Preload-style run of 65536 writes wraps word_cnt to 0.

Source files
------------

// File: rtl/pix_pack_240.sv
// pix_pack_240: write-side pixel packer for the 240-bit x 32-deep pixel buffer FIFO.
//
// Packs PIX_PER_WORD consecutive PIX_W-bit pixels into one FIFO word, first pixel in the
// least significant slot. A word is emitted when it fills up or when the line ends
// (pix_eol), in which case the unfilled slots are zero. Each emitted word produces a
// single-cycle fifo_wr_en pulse, one cycle after the completing accept.
//
// Ports:
//   wr_clk            write-domain clock (only clock)
//   wr_rst            synchronous, active-high reset
//   pix_valid/ready   pixel handshake; ready drops on FIFO almost-full, full or reset
//   pix_data          pixel value
//   pix_eol           last pixel of the line (qualified by the accept)
//   fifo_wr_en        FIFO write strobe, one cycle per word
//   fifo_wr_data      last completed word (held between writes)
//   fifo_almost_full  FIFO almost-full flag (backpressure)
//   fifo_full         FIFO full flag
//   word_cnt          words written since reset, wraps
//   ovf_err           sticky: a write was issued while fifo_full was high
module pix_pack_240 #(
    parameter int unsigned PIX_W        = 24,
    parameter int unsigned PIX_PER_WORD = 10,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    input  logic [PIX_W-1:0]              pix_data,
    input  logic                          pix_eol,
    output logic                          fifo_wr_en,
    output logic [PIX_W*PIX_PER_WORD-1:0] fifo_wr_data,
    input  logic                          fifo_almost_full,
    input  logic                          fifo_full,
    output logic [CNT_W-1:0]              word_cnt,
    output logic                          ovf_err
);

    localparam int unsigned    WORD_W = PIX_W * PIX_PER_WORD;
    localparam int unsigned    K_W    = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(PIX_PER_WORD - 1);

    if (WORD_W != 240) begin : g_width_check
        $error("pix_pack_240: PIX_W*PIX_PER_WORD must equal 240");
    end

    typedef enum logic [0:0] {
        StEmpty,
        StFill
    } state_t;

    state_t             r_state;
    logic [WORD_W-1:0]  r_acc;
    logic [K_W-1:0]     r_k;
    logic               r_wr_en;
    logic [WORD_W-1:0]  r_wr_data;
    logic [CNT_W-1:0]   r_word_cnt;
    logic               r_ovf;

    logic               w_acc;
    logic               w_last;
    logic               w_done;
    logic [WORD_W-1:0]  w_word;

    assign pix_ready = ~fifo_almost_full & ~fifo_full & ~wr_rst;

    always_comb begin
        w_acc  = pix_valid & pix_ready;
        // Last slot can only be reached from the FILL state (unless a word is one pixel).
        w_last = (PIX_PER_WORD == 1) ? 1'b1 : ((r_state == StFill) && (r_k == K_LAST));
        w_done = w_acc & (pix_eol | w_last);
        // Current accumulator with the incoming pixel merged into slot k.
        w_word = r_acc;
        for (int unsigned s = 0; s < PIX_PER_WORD; s++) begin
            if (r_k == K_W'(s)) begin
                w_word[s*PIX_W +: PIX_W] = pix_data;
            end
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_state    <= StEmpty;
            r_acc      <= '0;
            r_k        <= '0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
            r_word_cnt <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;

            if (r_wr_en) begin
                r_word_cnt <= r_word_cnt + 1'b1;
                // The write still goes out; the FIFO drops it.
                if (fifo_full) begin
                    r_ovf <= 1'b1;
                end
            end

            if (w_acc) begin
                if (w_done) begin
                    r_wr_data <= w_word;
                    r_wr_en   <= 1'b1;
                    r_acc     <= '0;
                    r_k       <= '0;
                    r_state   <= StEmpty;
                end else begin
                    r_acc     <= w_word;
                    r_k       <= r_k + 1'b1;
                    r_state   <= StFill;
                end
            end
        end
    end

    // A word pending in the output register at a reset cycle is never written.
    assign fifo_wr_en   = r_wr_en & ~wr_rst;
    assign fifo_wr_data = r_wr_data;
    assign word_cnt     = r_word_cnt;
    assign ovf_err      = r_ovf;

endmodule

// File: tb/tb_pix_pack_240.sv
// tb_pix_pack_240: self-checking bench for pix_pack_240.
// A reference model keeps the pixels of the word under construction in a queue and packs
// them when ten have arrived or the line ends; every cycle all outputs are compared.
module tb_pix_pack_240;

    logic         wr_clk = 1'b0;
    logic         wr_rst;
    logic         pix_valid;
    logic         pix_ready;
    logic [23:0]  pix_data;
    logic         pix_eol;
    logic         fifo_wr_en;
    logic [239:0] fifo_wr_data;
    logic         fifo_almost_full;
    logic         fifo_full;
    logic [15:0]  word_cnt;
    logic         ovf_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state: expected outputs during the current cycle.
    logic [23:0]  m_pix[$];
    logic         m_wr_en;
    logic [239:0] m_data;
    logic [31:0]  m_cnt;
    logic         m_ovf;

    always #5 wr_clk = ~wr_clk;

    pix_pack_240 #(
        .PIX_W        (24),
        .PIX_PER_WORD (10),
        .CNT_W        (16)
    ) dut (
        .wr_clk           (wr_clk),
        .wr_rst           (wr_rst),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .pix_data         (pix_data),
        .pix_eol          (pix_eol),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_wr_data     (fifo_wr_data),
        .fifo_almost_full (fifo_almost_full),
        .fifo_full        (fifo_full),
        .word_cnt         (word_cnt),
        .ovf_err          (ovf_err)
    );

    task automatic check_eq(input string tag, input logic [239:0] got, input logic [239:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Check outputs mid-cycle, then advance the model on the clock edge.
    task automatic tick();
        logic         acc;
        logic [239:0] w;
        logic         nxt;
        @(negedge wr_clk);
        check_eq("pix_ready", pix_ready, !fifo_almost_full && !fifo_full && !wr_rst);
        check_eq("fifo_wr_en", fifo_wr_en, m_wr_en && !wr_rst);
        check_eq("fifo_wr_data", fifo_wr_data, m_data);
        check_eq("word_cnt", word_cnt, m_cnt[15:0]);
        check_eq("ovf_err", ovf_err, m_ovf);
        @(posedge wr_clk);
        acc = pix_valid && !fifo_almost_full && !fifo_full && !wr_rst;
        if (wr_rst) begin
            m_pix.delete();
            m_wr_en = 1'b0;
            m_data  = '0;
            m_cnt   = '0;
            m_ovf   = 1'b0;
        end else begin
            if (m_wr_en) begin
                m_cnt = m_cnt + 1;
                if (fifo_full) m_ovf = 1'b1;
            end
            nxt = 1'b0;
            if (acc) begin
                m_pix.push_back(pix_data);
                if (m_pix.size() == 10 || pix_eol) begin
                    w = '0;
                    for (int i = 0; i < m_pix.size(); i++) w[i*24 +: 24] = m_pix[i];
                    m_data = w;
                    nxt    = 1'b1;
                    m_pix.delete();
                end
            end
            m_wr_en = nxt;
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [23:0] d, input logic e,
                         input logic af, input logic fl, input logic r);
        pix_valid        = v;
        pix_data         = d;
        pix_eol          = e;
        fifo_almost_full = af;
        fifo_full        = fl;
        wr_rst           = r;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pixels(input int n, input logic [23:0] base, input logic eol_last);
        for (int i = 0; i < n; i++)
            drive(1'b1, base + 24'(i), eol_last && (i == n - 1), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Power-up reset before the model is trusted.
        pix_valid = 0; pix_data = 0; pix_eol = 0;
        fifo_almost_full = 0; fifo_full = 0; wr_rst = 1;
        repeat (2) @(posedge wr_clk);
        #1;
        m_wr_en = 0; m_data = '0; m_cnt = '0; m_ovf = 0;
        drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_wr_data", fifo_wr_data, 240'h0);
        check_eq("rst_word_cnt", word_cnt, 16'd0);
        check_eq("rst_ovf", ovf_err, 1'b0);

        // One full word of 1..10.
        pixels(10, 24'd1, 1'b0);
        idle(2);
        check_eq("w1_cnt", word_cnt, 16'd1);
        check_eq("w1_slot0", fifo_wr_data[23:0], 24'd1);
        check_eq("w1_slot9", fifo_wr_data[239:216], 24'd10);

        // Sustained stream, ten words back to back.
        pixels(100, 24'd0, 1'b0);
        idle(2);
        check_eq("w100_cnt", word_cnt, 16'd11);

        // EOL flush of a partial word, then a fresh word.
        pixels(13, 24'h100, 1'b1);
        idle(1);
        check_eq("eol_pad", fifo_wr_data[239:72], 168'h0);
        check_eq("eol_slot2", fifo_wr_data[71:48], 24'h10C);
        pixels(10, 24'h200, 1'b0);
        idle(2);

        // Almost-full stall mid-word with valid held.
        pixels(4, 24'h300, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 24'h304, 1'b0, 1'b1, 1'b0, 1'b0);
        pixels(6, 24'h304, 1'b0);
        idle(2);
        check_eq("stall_slot9", fifo_wr_data[239:216], 24'h309);

        // Reset mid-word discards the partial word.
        pixels(4, 24'h400, 1'b0);
        drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        pixels(10, 24'hA, 1'b0);
        idle(2);
        check_eq("rstmid_cnt", word_cnt, 16'd1);
        check_eq("rstmid_slot0", fifo_wr_data[23:0], 24'hA);

        // Wrap: 65535 single-pixel EOL words back to back, then one overflowing write.
        drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 65535; i++) drive(1'b1, 24'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        pixels(10, 24'h500, 1'b0);
        drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        check_eq("wrap_cnt", word_cnt, 16'd0);
        check_eq("ovf_sticky", ovf_err, 1'b1);

        // Randomized traffic with backpressure, full and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 8), 24'($urandom), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 199) == 0));
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
